// File: rtl/pipelined_vector_decoder_if.sv
// Handshake and decoded micro-op bundle between fetch, decode and register-read.
interface pipelined_vector_decoder_if #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned REG_W   = 4,
   parameter int unsigned BEATS   = 4
);
   localparam int unsigned IMM_W  = INSTR_W - 4 - REG_W;
   localparam int unsigned BEAT_W = $clog2(BEATS);

   // Fetch side
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] instruction;
   logic               flush;

   // Register-read side
   logic               out_valid;
   logic               out_ready;
   logic               MemoryWrite;
   logic               RegWriteEn;
   logic [1:0]         WriteRegFrom;
   logic [REG_W-1:0]   RegToWrite;
   logic [REG_W-1:0]   RegSrcA;
   logic [REG_W-1:0]   RegSrcB;
   logic [IMM_W-1:0]   Immediate;
   logic               IsVector;
   logic [BEAT_W-1:0]  Beat;
   logic               LastBeat;
   logic               IllegalOp;

   // Environment side: drives instructions and consumes micro-ops
   modport master (
      output in_valid, instruction, flush, out_ready,
      input  in_ready, out_valid, MemoryWrite, RegWriteEn, WriteRegFrom, RegToWrite,
             RegSrcA, RegSrcB, Immediate, IsVector, Beat, LastBeat, IllegalOp
   );

   // Decode stage side
   modport slave (
      input  in_valid, instruction, flush, out_ready,
      output in_ready, out_valid, MemoryWrite, RegWriteEn, WriteRegFrom, RegToWrite,
             RegSrcA, RegSrcB, Immediate, IsVector, Beat, LastBeat, IllegalOp
   );
endinterface

// File: rtl/pipelined_vector_decoder.sv
// Registered decode stage: scalar ops issue one micro-op, vector ops expand into
// BEATS micro-ops (one per lane group) while fetch is stalled.
module pipelined_vector_decoder #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned REG_W   = 4,
   parameter int unsigned BEATS   = 4
) (
   input logic                    clk,
   input logic                    rst,
   pipelined_vector_decoder_if.slave bus
);
   localparam int unsigned IMM_W  = INSTR_W - 4 - REG_W;
   localparam int unsigned BEAT_W = $clog2(BEATS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {StIdle, StHold, StExpand} state_e;

   typedef struct packed {
      logic       reg_we;
      logic       mem_we;
      logic [1:0] wr_from;
      logic       is_vec;
      logic       illegal;
   } decode_t;

   // Opcode table; anything not listed is illegal with all enables low.
   function automatic decode_t decode_op(input logic [3:0] op);
      decode_t d;
      d = '0;
      case (op)
         4'h0: ;
         4'h1, 4'h2, 4'h5: d.reg_we = 1'b1;
         4'h3: begin d.reg_we = 1'b1; d.wr_from = 2'b10; end
         4'h4: d.mem_we = 1'b1;
         4'h8: begin d.reg_we = 1'b1; d.wr_from = 2'b11; d.is_vec = 1'b1; end
         4'h9: begin d.reg_we = 1'b1; d.wr_from = 2'b10; d.is_vec = 1'b1; end
         4'hA: begin d.mem_we = 1'b1; d.is_vec = 1'b1; end
         4'hF: begin d.reg_we = 1'b1; d.wr_from = 2'b01; end
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

   state_e              state_q, state_d;
   logic [INSTR_W-1:0]  instr_q;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                accept;
   logic                out_valid;
   logic                in_is_vec;
   decode_t             held;
   logic [IMM_W-1:0]    imm;

   assign out_valid   = (state_q != StIdle);
   assign bus.in_ready = (state_q != StExpand) && (!out_valid || bus.out_ready) && !bus.flush;
   assign accept      = bus.in_valid && bus.in_ready;
   assign in_is_vec   = decode_op(bus.instruction[INSTR_W-1 -: 4]).is_vec;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state and beat counter; flush wins over everything else
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      if (bus.flush) begin
         state_d = StIdle;
         beat_d  = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  state_d = in_is_vec ? StExpand : StHold;
                  beat_d  = '0;
               end
            end
            StHold: begin
               if (bus.out_ready) begin
                  if (accept) begin
                     state_d = in_is_vec ? StExpand : StHold;
                     beat_d  = '0;
                  end else begin
                     state_d = StIdle;
                     beat_d  = '0;
                  end
               end
            end
            StExpand: begin
               if (bus.out_ready) begin
                  beat_d = beat_q + 1'b1;
                  if (beat_d == LAST_BEAT) state_d = StHold;
               end
            end
            default: begin
               state_d = StIdle;
               beat_d  = '0;
            end
         endcase
      end
   end

   // Held instruction and beat index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= '0;
         beat_q  <= '0;
      end else begin
         beat_q <= beat_d;
         if (accept) instr_q <= bus.instruction;
      end
   end

   assign held = decode_op(instr_q[INSTR_W-1 -: 4]);
   assign imm  = instr_q[IMM_W-1:0];

   // Micro-op outputs, all held at zero while no micro-op is valid
   always_comb begin
      bus.out_valid    = out_valid;
      bus.MemoryWrite  = 1'b0;
      bus.RegWriteEn   = 1'b0;
      bus.WriteRegFrom = 2'b00;
      bus.RegToWrite   = '0;
      bus.RegSrcA      = '0;
      bus.RegSrcB      = '0;
      bus.Immediate    = '0;
      bus.IsVector     = 1'b0;
      bus.Beat         = '0;
      bus.LastBeat     = 1'b0;
      bus.IllegalOp    = 1'b0;
      if (out_valid) begin
         bus.MemoryWrite  = held.mem_we;
         bus.RegWriteEn   = held.reg_we;
         bus.WriteRegFrom = held.wr_from;
         bus.RegToWrite   = instr_q[INSTR_W-5 -: REG_W];
         bus.RegSrcA      = imm[2*REG_W-1:REG_W];
         bus.RegSrcB      = imm[REG_W-1:0];
         bus.Immediate    = imm;
         bus.IsVector     = held.is_vec;
         bus.Beat         = beat_q;
         bus.LastBeat     = (state_q == StHold);
         bus.IllegalOp    = held.illegal;
      end
   end
endmodule

// File: tb/tb_pipelined_vector_decoder.sv
module tb_pipelined_vector_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   pipelined_vector_decoder_if #(.INSTR_W(16), .REG_W(4), .BEATS(4)) bus ();

   pipelined_vector_decoder #(.INSTR_W(16), .REG_W(4), .BEATS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic        reg_we;
      logic        mem_we;
      logic [1:0]  wr_from;
      logic [3:0]  rd;
      logic [3:0]  sa;
      logic [3:0]  sb;
      logic [7:0]  imm;
      logic        illegal;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string what, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h, want %0h", what, idx, act, exp);
      end
   endtask

   task automatic chk_scalar(input int i);
      chk("out_valid", i, 32'(bus.out_valid), 32'd1);
      chk("RegWriteEn", i, 32'(bus.RegWriteEn), 32'(tbl[i].reg_we));
      chk("MemoryWrite", i, 32'(bus.MemoryWrite), 32'(tbl[i].mem_we));
      chk("WriteRegFrom", i, 32'(bus.WriteRegFrom), 32'(tbl[i].wr_from));
      chk("RegToWrite", i, 32'(bus.RegToWrite), 32'(tbl[i].rd));
      chk("RegSrcA", i, 32'(bus.RegSrcA), 32'(tbl[i].sa));
      chk("RegSrcB", i, 32'(bus.RegSrcB), 32'(tbl[i].sb));
      chk("Immediate", i, 32'(bus.Immediate), 32'(tbl[i].imm));
      chk("IllegalOp", i, 32'(bus.IllegalOp), 32'(tbl[i].illegal));
      chk("IsVector", i, 32'(bus.IsVector), 32'd0);
      chk("Beat", i, 32'(bus.Beat), 32'd0);
      chk("LastBeat", i, 32'(bus.LastBeat), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs;
      int exp_beat;
      int cyc;
      //           instr     we    mw    wrf    rd    sa    sb    imm    ill
      tbl[0] = '{16'hF39D, 1'b1, 1'b0, 2'b01, 4'h3, 4'h9, 4'hD, 8'h9D, 1'b0};
      tbl[1] = '{16'h5678, 1'b1, 1'b0, 2'b00, 4'h6, 4'h7, 4'h8, 8'h78, 1'b0};
      tbl[2] = '{16'h7ABC, 1'b0, 1'b0, 2'b00, 4'hA, 4'hB, 4'hC, 8'hBC, 1'b1};
      tbl[3] = '{16'h3412, 1'b1, 1'b0, 2'b10, 4'h4, 4'h1, 4'h2, 8'h12, 1'b0};
      tbl[4] = '{16'h4A55, 1'b0, 1'b1, 2'b00, 4'hA, 4'h5, 4'h5, 8'h55, 1'b0};
      tbl[5] = '{16'h0000, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0};
      tbl[6] = '{16'h2FFF, 1'b1, 1'b0, 2'b00, 4'hF, 4'hF, 4'hF, 8'hFF, 1'b0};
      tbl[7] = '{16'h1123, 1'b1, 1'b0, 2'b00, 4'h1, 4'h2, 4'h3, 8'h23, 1'b0};
      tbl[8] = '{16'hE001, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h1, 8'h01, 1'b1};
      tbl[9] = '{16'h6C3A, 1'b0, 1'b0, 2'b00, 4'hC, 4'h3, 4'hA, 8'h3A, 1'b1};

      bus.in_valid    = 1'b0;
      bus.instruction = '0;
      bus.flush       = 1'b0;
      bus.out_ready   = 1'b1;

      // Reset state
      #1;
      chk("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
      chk("rst_Beat", 0, 32'(bus.Beat), 32'd0);
      chk("rst_RegWriteEn", 0, 32'(bus.RegWriteEn), 32'd0);
      chk("rst_LastBeat", 0, 32'(bus.LastBeat), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Scalar table, issued back to back; in_ready must stay high throughout
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0) chk_scalar(i - 1);
         bus.in_valid    = 1'b1;
         bus.instruction = tbl[i].instr;
         #1;
         chk("in_ready", i, 32'(bus.in_ready), 32'd1);
      end
      @(negedge clk);
      chk_scalar(9);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("idle_out_valid", 0, 32'(bus.out_valid), 32'd0);
      chk("idle_RegWriteEn", 0, 32'(bus.RegWriteEn), 32'd0);

      // VADD expansion, out_ready held high
      bus.in_valid    = 1'b1;
      bus.instruction = 16'h8312;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         #1;
         chk("vadd_out_valid", k, 32'(bus.out_valid), 32'd1);
         chk("vadd_Beat", k, 32'(bus.Beat), 32'(k));
         chk("vadd_LastBeat", k, 32'(bus.LastBeat), 32'(k == 3));
         chk("vadd_in_ready", k, 32'(bus.in_ready), 32'(k == 3));
         chk("vadd_WriteRegFrom", k, 32'(bus.WriteRegFrom), 32'd3);
         chk("vadd_RegSrcA", k, 32'(bus.RegSrcA), 32'd1);
         chk("vadd_RegSrcB", k, 32'(bus.RegSrcB), 32'd2);
         chk("vadd_IsVector", k, 32'(bus.IsVector), 32'd1);
      end
      @(negedge clk);
      chk("vadd_done", 0, 32'(bus.out_valid), 32'd0);

      // VST with out_ready toggling; beat advances only on handshakes
      bus.in_valid    = 1'b1;
      bus.instruction = 16'hA045;
      bus.out_ready   = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      hs       = 0;
      exp_beat = 0;
      cyc      = 0;
      while (bus.out_valid && cyc < 20) begin
         chk("vst_Beat", cyc, 32'(bus.Beat), 32'(exp_beat));
         chk("vst_MemoryWrite", cyc, 32'(bus.MemoryWrite), 32'd1);
         chk("vst_RegWriteEn", cyc, 32'(bus.RegWriteEn), 32'd0);
         bus.out_ready = (cyc % 2 == 0);
         if (bus.out_ready) begin
            hs++;
            exp_beat++;
         end
         cyc++;
         @(negedge clk);
      end
      chk("vst_handshakes", 0, 32'(hs), 32'd4);
      chk("vst_ended", 0, 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;

      // Flush at beat 1 of VLD; the pending instruction must not be accepted
      bus.in_valid    = 1'b1;
      bus.instruction = 16'h9100;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("vld_Beat0", 0, 32'(bus.Beat), 32'd0);
      @(negedge clk);
      chk("vld_Beat1", 0, 32'(bus.Beat), 32'd1);
      bus.flush       = 1'b1;
      bus.in_valid    = 1'b1;
      bus.instruction = 16'h0000;
      #1;
      chk("flush_in_ready", 0, 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      chk("flush_out_valid", 0, 32'(bus.out_valid), 32'd0);
      chk("flush_Beat", 0, 32'(bus.Beat), 32'd0);
      chk("flush_in_ready_after", 0, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("post_flush_valid", 0, 32'(bus.out_valid), 32'd1);
      chk("post_flush_Beat", 0, 32'(bus.Beat), 32'd0);
      chk("post_flush_IsVector", 0, 32'(bus.IsVector), 32'd0);
      chk("post_flush_LastBeat", 0, 32'(bus.LastBeat), 32'd1);
      @(negedge clk);

      // Reset in the middle of a VADD expansion
      bus.in_valid    = 1'b1;
      bus.instruction = 16'h8312;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_Beat", 0, 32'(bus.Beat), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", 0, 32'(bus.out_valid), 32'd0);
      chk("rst_mid_Beat", 0, 32'(bus.Beat), 32'd0);
      chk("rst_mid_WriteRegFrom", 0, 32'(bus.WriteRegFrom), 32'd0);
      chk("rst_mid_IsVector", 0, 32'(bus.IsVector), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_rel_in_ready", 0, 32'(bus.in_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_no_partial", k, 32'(bus.out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
